// File: rtl/jtframe_dwnld_pack.sv
// Packs downloader bytes into masked 16-bit SDRAM writes through a small FIFO.
// Each byte becomes one prog_we/prog_rdy transaction; dwnld_busy covers the drain after download ends.
module jtframe_dwnld_pack #(
    parameter logic [24:0] BA1_START = 25'h040_0000,
    parameter logic [24:0] BA2_START = 25'h080_0000,
    parameter logic [24:0] BA3_START = 25'h0C0_0000,
    parameter bit          SWAB      = 1'b0,
    parameter int          FIFO_AW   = 2
)(
    input  logic        clk_rom,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_ba,
    output logic        prog_we,
    output logic        prog_rd,
    input  logic        prog_rdy,
    input  logic        prog_ack,
    output logic        dwnld_busy,
    output logic        overflow
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

    typedef struct packed {
        logic [1:0]  ba;
        logic [21:0] addr;
        logic        hi;
        logic [7:0]  data;
    } entry_t;

    entry_t             fifo_mem [DEPTH];
    entry_t             new_entry;
    entry_t             head;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               empty;
    logic               push;
    logic               drop;
    logic               pop;
    logic               load;
    logic               we_next;
    logic [1:0]         bank;
    logic [24:0]        base;
    logic [24:0]        offset;
    logic               downloading_d;
    state_t             state;
    state_t             state_next;

    // prog_ack is informational only and offsets beyond the bank size are discarded
    wire unused = &{1'b0, prog_ack, offset[24:23]};

    assign full    = (count == DEPTH[FIFO_AW:0]);
    assign empty   = (count == '0);
    assign push    = downloading & ioctl_wr & ~full;
    assign drop    = downloading & ioctl_wr & full;
    assign head    = fifo_mem[rd_ptr];
    assign prog_rd = 1'b0;

    always_comb begin
        bank = 2'd0;
        base = '0;
        if (ioctl_addr >= BA3_START) begin
            bank = 2'd3;
            base = BA3_START;
        end else if (ioctl_addr >= BA2_START) begin
            bank = 2'd2;
            base = BA2_START;
        end else if (ioctl_addr >= BA1_START) begin
            bank = 2'd1;
            base = BA1_START;
        end
        offset    = ioctl_addr - base;
        new_entry = '{ba: bank, addr: offset[22:1], hi: offset[0] ^ SWAB, data: ioctl_data};
    end

    always_ff @(posedge clk_rom) begin
        if (push) fifo_mem[wr_ptr] <= new_entry;
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!empty) state_next = WRITE;
            WRITE:   if (prog_we && prog_rdy) state_next = GAP;
            GAP:     state_next = empty ? IDLE : WRITE;
            default: state_next = IDLE;
        endcase
    end

    // From GAP the new head is loaded and requested together, so prog_we is low for a single cycle
    always_comb begin
        pop     = (state == WRITE) && prog_we && prog_rdy;
        load    = (state != WRITE) && (state_next == WRITE);
        we_next = 1'b0;
        case (state)
            IDLE:    we_next = 1'b0;
            WRITE:   we_next = !pop;
            GAP:     we_next = !empty;
            default: we_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            prog_addr     <= '0;
            prog_data     <= '0;
            prog_mask     <= '0;
            prog_ba       <= '0;
            prog_we       <= 1'b0;
            overflow      <= 1'b0;
            downloading_d <= 1'b0;
            dwnld_busy    <= 1'b0;
        end else begin
            prog_we <= we_next;
            if (load) begin
                prog_addr <= head.addr;
                prog_data <= {head.data, head.data};
                prog_mask <= head.hi ? 2'b01 : 2'b10;
                prog_ba   <= head.ba;
            end
            overflow      <= ((downloading && !downloading_d) ? 1'b0 : overflow) | drop;
            downloading_d <= downloading;
            dwnld_busy    <= downloading | ~empty | (state != IDLE);
        end
    end
endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Self-checking bench for jtframe_dwnld_pack: a queue model of pending writes checked every cycle,
// plus directed vectors with literal expectations for timing, banking, overflow, drain and reset.
module tb_jtframe_dwnld_pack;
    logic        clk_rom = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic        prog_rdy;
    logic        prog_ack = 1'b0;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_ba;
    logic        prog_we;
    logic        prog_rd;
    logic        dwnld_busy;
    logic        overflow;
    logic [21:0] sw_addr;
    logic [15:0] sw_data;
    logic [1:0]  sw_mask;
    logic [1:0]  sw_ba;
    logic        sw_we;
    logic        sw_rd;
    logic        sw_busy;
    logic        sw_overflow;

    always #5 clk_rom = ~clk_rom;

    jtframe_dwnld_pack u_dut (
        .clk_rom(clk_rom), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask), .prog_ba(prog_ba),
        .prog_we(prog_we), .prog_rd(prog_rd), .prog_rdy(prog_rdy), .prog_ack(prog_ack),
        .dwnld_busy(dwnld_busy), .overflow(overflow)
    );

    jtframe_dwnld_pack #(.SWAB(1'b1)) u_swab (
        .clk_rom(clk_rom), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(sw_addr), .prog_data(sw_data), .prog_mask(sw_mask), .prog_ba(sw_ba),
        .prog_we(sw_we), .prog_rd(sw_rd), .prog_rdy(prog_rdy), .prog_ack(prog_ack),
        .dwnld_busy(sw_busy), .overflow(sw_overflow)
    );

    typedef struct {
        logic [1:0]  ba;
        logic [21:0] addr;
        logic [1:0]  mask;
        logic [15:0] data;
    } wr_t;

    wr_t model_q[$];
    int  checks = 0;
    int  errors = 0;
    int  writes_done = 0;
    bit  ovf_model = 1'b0;
    bit  prev_dl = 1'b0;
    bit  rdy_en = 1'b0;
    int  rdy_delay = 1;
    int  we_cnt = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s timed out at %0t", name, $time);
    endtask

    // Expected write derived from the address map with plain arithmetic
    function automatic wr_t expectWrite(input logic [24:0] a, input logic [7:0] d, input bit swab);
        wr_t         w;
        int unsigned base;
        int unsigned off;
        bit          odd;
        if (a >= 25'h0C0_0000)      begin w.ba = 2'd3; base = 32'h0C0_0000; end
        else if (a >= 25'h080_0000) begin w.ba = 2'd2; base = 32'h080_0000; end
        else if (a >= 25'h040_0000) begin w.ba = 2'd1; base = 32'h040_0000; end
        else                        begin w.ba = 2'd0; base = 0; end
        off    = (32'(a) - base) % 32'h0080_0000;
        odd    = (off % 2) == 1;
        w.addr = 22'(off / 2);
        w.mask = (odd ^ swab) ? 2'b01 : 2'b10;
        w.data = {d, d};
        return w;
    endfunction

    always @(negedge clk_rom) begin
        bit  full;
        wr_t w;
        if (!rst_n) begin
            model_q.delete();
            ovf_model = 1'b0;
            prev_dl   = 1'b0;
        end else begin
            checkOutput("prog_rd", 64'(prog_rd), 64'(0));
            checkOutput("overflow", 64'(overflow), 64'(ovf_model));
            checkOutput("we_without_pending", 64'(prog_we && model_q.size() == 0), 64'(0));
            if (prog_we && model_q.size() > 0) begin
                w = model_q[0];
                checkOutput("write_fields", 64'({prog_ba, prog_addr, prog_mask, prog_data}),
                            64'({w.ba, w.addr, w.mask, w.data}));
            end
            full = model_q.size() >= 4;
            if (prog_we && prog_rdy && model_q.size() > 0) begin
                void'(model_q.pop_front());
                writes_done++;
            end
            if (downloading && !prev_dl) ovf_model = 1'b0;
            if (downloading && ioctl_wr) begin
                if (full) ovf_model = 1'b1;
                else      model_q.push_back(expectWrite(ioctl_addr, ioctl_data, 1'b0));
            end
            prev_dl = downloading;
        end
    end

    // Controller stand-in: answers prog_rdy after rdy_delay cycles of prog_we
    initial begin
        prog_rdy = 1'b0;
        forever begin
            @(posedge clk_rom);
            #1;
            if (prog_rdy) begin
                prog_rdy = 1'b0;
                we_cnt   = 0;
            end else if (rdy_en && prog_we) begin
                we_cnt++;
                if (we_cnt >= rdy_delay) prog_rdy = 1'b1;
            end else begin
                we_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_rom);
        #1;
    endtask

    task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic waitWeRise();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (prog_we) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) timeoutFail("wait_prog_we");
    endtask

    task automatic waitIdle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (model_q.size() == 0 && !prog_we) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) timeoutFail("wait_drain");
    endtask

    logic [24:0] v_addr [5] = '{25'h040_0003, 25'h080_0005, 25'h0C0_0010, 25'h03F_FFFF, 25'h1FF_FFFE};
    logic [7:0]  v_data [5] = '{8'h3C, 8'h5A, 8'hC3, 8'h81, 8'h7E};
    logic [1:0]  v_ba   [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    logic [21:0] v_paddr[5] = '{22'h1, 22'h2, 22'h8, 22'h1F_FFFF, 22'h1F_FFFF};
    logic [1:0]  v_mask [5] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0]  v_smask[5] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b01};

    initial begin
        int base;
        int hi;
        int lo;
        int n;
        bit busy_dropped;

        repeat (3) tick();
        checkOutput("reset_outputs",
                    64'({prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd, dwnld_busy, overflow}), 64'(0));
        rst_n = 1'b1;
        tick();

        downloading = 1'b1;
        tick();
        tick();
        checkOutput("busy_while_downloading", 64'(dwnld_busy), 64'(1));
        rdy_en    = 1'b1;
        rdy_delay = 3;
        applyStimulus(25'h0, 8'hA5);
        checkOutput("latency_edge_k", 64'(prog_we), 64'(0));
        tick();
        checkOutput("latency_edge_k1", 64'(prog_we), 64'(0));
        tick();
        checkOutput("latency_edge_k2", 64'(prog_we), 64'(1));
        checkOutput("first_write", 64'({prog_ba, prog_addr, prog_data, prog_mask}),
                    64'({2'd0, 22'd0, 16'hA5A5, 2'b10}));
        waitIdle();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(v_addr[i], v_data[i]);
            waitWeRise();
            checkOutput($sformatf("bank_map_%0d", i), 64'({prog_ba, prog_addr, prog_mask, prog_data}),
                        64'({v_ba[i], v_paddr[i], v_mask[i], v_data[i], v_data[i]}));
            checkOutput($sformatf("swab_mask_%0d", i), 64'(sw_mask), 64'(v_smask[i]));
            waitIdle();
        end

        rdy_en = 1'b0;
        checkOutput("overflow_before_burst", 64'(overflow), 64'(0));
        for (int i = 0; i < 6; i++) applyStimulus(25'h10 + 25'(i), 8'h10 + 8'(i));
        tick();
        checkOutput("burst_overflow", 64'(overflow), 64'(1));
        base      = writes_done;
        rdy_en    = 1'b1;
        rdy_delay = 1;
        waitIdle();
        checkOutput("burst_writes", 64'(writes_done - base), 64'(4));

        downloading = 1'b0;
        tick();
        applyStimulus(25'h50, 8'hEE);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (prog_we) n++;
            tick();
        end
        checkOutput("ignored_strobe_writes", 64'(n), 64'(0));
        checkOutput("overflow_sticky", 64'(overflow), 64'(1));
        downloading = 1'b1;
        tick();
        checkOutput("overflow_cleared_on_rise", 64'(overflow), 64'(0));

        rdy_delay = 7;
        applyStimulus(25'h20, 8'h11);
        applyStimulus(25'h21, 8'h22);
        waitWeRise();
        hi = 0;
        while (prog_we && hi < 50) begin hi++; tick(); end
        lo = 0;
        while (!prog_we && lo < 50) begin lo++; tick(); end
        checkOutput("we_high_cycles", 64'(hi), 64'(7));
        checkOutput("we_gap_cycles", 64'(lo), 64'(1));
        waitIdle();

        rdy_en = 1'b0;
        applyStimulus(25'h30, 8'h31);
        applyStimulus(25'h31, 8'h32);
        applyStimulus(25'h32, 8'h33);
        downloading = 1'b0;
        tick();
        tick();
        checkOutput("busy_after_download_end", 64'(dwnld_busy), 64'(1));
        rdy_en       = 1'b1;
        rdy_delay    = 2;
        n            = 0;
        busy_dropped = 1'b0;
        for (int c = 0; c < 100 && n < 3; c++) begin
            if (prog_rdy && prog_we) n++;
            if (!dwnld_busy) busy_dropped = 1'b1;
            tick();
        end
        checkOutput("drain_rdy_count", 64'(n), 64'(3));
        checkOutput("busy_held_during_drain", 64'(busy_dropped), 64'(0));
        checkOutput("busy_after_last_rdy", 64'(dwnld_busy), 64'(1));
        tick();
        checkOutput("busy_gap_cycle", 64'(dwnld_busy), 64'(1));
        tick();
        checkOutput("busy_fall", 64'(dwnld_busy), 64'(0));

        downloading = 1'b1;
        rdy_en      = 1'b0;
        tick();
        applyStimulus(25'h40, 8'h99);
        applyStimulus(25'h41, 8'h98);
        waitWeRise();
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async",
                    64'({prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd, dwnld_busy, overflow}), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        base      = writes_done;
        rdy_en    = 1'b1;
        rdy_delay = 2;
        applyStimulus(25'h2, 8'hB7);
        waitWeRise();
        checkOutput("post_reset_write", 64'({prog_ba, prog_addr, prog_data, prog_mask}),
                    64'({2'd0, 22'd1, 16'hB7B7, 2'b10}));
        waitIdle();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (prog_we) n++;
            tick();
        end
        checkOutput("no_stale_write", 64'(n), 64'(0));
        checkOutput("post_reset_write_count", 64'(writes_done - base), 64'(1));

        downloading = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end
endmodule
